lif_neuron_array: RTL and testbench

Parametrised, time-multiplexed array of leaky integrate-and-fire neurons for the second spiking layer. It generalises the single-neuron accumulate/compare/reset cell to N neurons that share one datapath, adding several features: configurable leak, selectable reset mode, refractory period, saturating arithmetic, and an input handshake. Weighted MAC contributions are accumulated per neuron between timestep pulses. Each `pulse` triggers a sequential membrane-update sweep that emits a spike vector.

---
 rtl/lif_neuron_array.sv | 207 ++++++++++++++++++++
 tb/tb_lif_neuron_array.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lif_neuron_array.sv
// -----------------------------------------------------------------------------
// lif_neuron_array
//
// Time-multiplexed array of leaky integrate-and-fire neurons. The neurons
// share a single update datapath. Weighted contributions are accumulated per
// neuron while the array is idle. Each timestep pulse starts a sweep that
// updates one neuron per clock and then publishes the resulting spike vector.
//
// Parameters
//   N_NEURONS  : neuron count (>= 2)
//   W          : signed width of inputs, currents, membranes and threshold
//   LEAK_SHIFT : leak term is v >>> LEAK_SHIFT (>= 1)
//   REFRAC     : refractory timesteps after a spike (0..15)
//   IDX_W      : width of in_idx (>= $clog2(N_NEURONS))
//
// Ports
//   clk        : rising-edge clock
//   reset      : asynchronous active-low reset
//   pulse      : timestep strobe; dropped (and flagged) while a sweep runs
//   in_valid   : contribution valid
//   in_ready   : contribution accepted when in_valid && in_ready (idle only)
//   in_idx     : target neuron; indices >= N_NEURONS are accepted and ignored
//   in_data    : signed contribution, saturating-added to the neuron current
//   threshold  : signed firing threshold (> 0), stable during a sweep
//   reset_mode : 0 = membrane to zero on spike, 1 = subtract threshold
//   spk_out    : spike vector of the last completed timestep
//   spk_valid  : one-cycle strobe when spk_out updates
//   busy       : sweep in progress
//   overrun    : sticky, set when a pulse is dropped
// -----------------------------------------------------------------------------
module lif_neuron_array #(
    parameter int N_NEURONS  = 4,
    parameter int W          = 8,
    parameter int LEAK_SHIFT = 1,
    parameter int REFRAC     = 2,
    parameter int IDX_W      = $clog2(N_NEURONS)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 pulse,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [IDX_W-1:0]     in_idx,
    input  logic signed [W-1:0]  in_data,
    input  logic signed [W-1:0]  threshold,
    input  logic                 reset_mode,
    output logic [N_NEURONS-1:0] spk_out,
    output logic                 spk_valid,
    output logic                 busy,
    output logic                 overrun
);

    localparam int AW = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1;
    localparam logic [AW-1:0]        LAST_IDX = AW'(N_NEURONS - 1);
    localparam logic [IDX_W:0]       N_LIM    = (IDX_W + 1)'(N_NEURONS);
    localparam logic [3:0]           REFRAC_V = 4'(REFRAC);
    localparam logic signed [W+1:0]  SAT_HI   = {3'b000, {(W-1){1'b1}}};
    localparam logic signed [W+1:0]  SAT_LO   = {3'b111, {(W-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_UPDATE,
        S_DONE
    } state_t;

    // Sign-extend a W-bit value to the W+2-bit working width.
    function automatic logic signed [W+1:0] ext(input logic signed [W-1:0] a);
        return {{2{a[W-1]}}, a};
    endfunction

    // Clamp a W+2-bit working value into the signed W-bit range.
    function automatic logic signed [W-1:0] sat(input logic signed [W+1:0] x);
        if (x > SAT_HI) begin
            return SAT_HI[W-1:0];
        end else if (x < SAT_LO) begin
            return SAT_LO[W-1:0];
        end else begin
            return x[W-1:0];
        end
    endfunction

    state_t                state_q, state_d;
    logic [AW-1:0]         idx_q;
    logic [N_NEURONS-1:0]  spk_acc_q;
    logic signed [W-1:0]   cur_q [N_NEURONS];
    logic signed [W-1:0]   mem_q [N_NEURONS];
    logic [3:0]            ref_q [N_NEURONS];

    // Input acceptance
    logic [AW-1:0]         in_sel;
    logic                  in_hit;

    assign in_sel = in_idx[AW-1:0];
    assign in_hit = in_valid && in_ready && ({1'b0, in_idx} < N_LIM);

    // Shared neuron-update datapath for neuron idx_q
    logic signed [W-1:0]   v_old, i_old, leak, v_sat, v_sub, v_new;
    logic signed [W+1:0]   v_full;
    logic [3:0]            r_old, r_new;
    logic                  fire;

    always_comb begin
        v_old  = mem_q[idx_q];
        i_old  = cur_q[idx_q];
        r_old  = ref_q[idx_q];
        leak   = v_old >>> LEAK_SHIFT;
        v_full = ext(v_old) - ext(leak) + ext(i_old);
        v_sat  = sat(v_full);
        v_sub  = sat(ext(v_sat) - ext(threshold));
        fire   = 1'b0;
        v_new  = v_old;
        r_new  = r_old;
        if (r_old != 4'd0) begin
            r_new = r_old - 4'd1;
        end else if (v_sat >= threshold) begin
            fire  = 1'b1;
            v_new = reset_mode ? v_sub : '0;
            r_new = REFRAC_V;
        end else begin
            v_new = v_sat;
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state and state-decoded outputs (no path from in_valid)
    always_comb begin
        state_d  = state_q;
        in_ready = 1'b0;
        busy     = 1'b1;
        case (state_q)
            S_IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (pulse) begin
                    state_d = S_UPDATE;
                end
            end
            S_UPDATE: begin
                if (idx_q == LAST_IDX) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Neuron state, sweep index and output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned k = 0; k < N_NEURONS; k++) begin
                cur_q[k] <= '0;
                mem_q[k] <= '0;
                ref_q[k] <= '0;
            end
            idx_q     <= '0;
            spk_acc_q <= '0;
            spk_out   <= '0;
            spk_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            spk_valid <= 1'b0;
            if (pulse && (state_q != S_IDLE)) begin
                overrun <= 1'b1;
            end
            case (state_q)
                S_IDLE: begin
                    // An input accepted on the pulse edge lands before neuron
                    // 0 is read, so it counts in the timestep being closed.
                    if (in_hit) begin
                        cur_q[in_sel] <= sat(ext(cur_q[in_sel]) + ext(in_data));
                    end
                    if (pulse) begin
                        idx_q     <= '0;
                        spk_acc_q <= '0;
                    end
                end
                S_UPDATE: begin
                    mem_q[idx_q]     <= v_new;
                    ref_q[idx_q]     <= r_new;
                    cur_q[idx_q]     <= '0;
                    spk_acc_q[idx_q] <= fire;
                    idx_q            <= idx_q + 1'b1;
                end
                S_DONE: begin
                    spk_out   <= spk_acc_q;
                    spk_valid <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lif_neuron_array.sv
// -----------------------------------------------------------------------------
// tb_lif_neuron_array
//
// Directed bench for lif_neuron_array (N_NEURONS=4, W=8, LEAK_SHIFT=1,
// REFRAC=2, threshold=10, IDX_W=3 so out-of-range indices can be driven).
// Stimulus pushes the expected spike vector and its arrival cycle into a
// scoreboard; a monitor pops and compares on every spk_valid.
// -----------------------------------------------------------------------------
module tb_lif_neuron_array;

    localparam int N     = 4;
    localparam int W     = 8;
    localparam int IDX_W = 3;

    logic                clk = 1'b0;
    logic                reset;
    logic                pulse;
    logic                in_valid;
    logic                in_ready;
    logic [IDX_W-1:0]    in_idx;
    logic signed [W-1:0] in_data;
    logic signed [W-1:0] threshold;
    logic                reset_mode;
    logic [N-1:0]        spk_out;
    logic                spk_valid;
    logic                busy;
    logic                overrun;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        logic [N-1:0] spk;
        int           cyc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    lif_neuron_array #(
        .N_NEURONS (N),
        .W         (W),
        .LEAK_SHIFT(1),
        .REFRAC    (2),
        .IDX_W     (IDX_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .pulse     (pulse),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_idx    (in_idx),
        .in_data   (in_data),
        .threshold (threshold),
        .reset_mode(reset_mode),
        .spk_out   (spk_out),
        .spk_valid (spk_valid),
        .busy      (busy),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every spk_valid must match the oldest expectation, on time.
    always @(negedge clk) begin
        if (reset === 1'b1 && spk_valid !== 1'b0) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spk_valid_unexpected actual=%b expected=0 (cycle %0d)", spk_valid, cyc);
            end else begin
                mon_e = sb.pop_front();
                chk("spk_out", 32'(spk_out), 32'(mon_e.spk));
                chk("spk_latency", cyc, mon_e.cyc);
            end
        end
    end

    task automatic inject(input logic [IDX_W-1:0] idx, input logic signed [W-1:0] d);
        @(negedge clk);
        chk("in_ready_idle", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_idx   = idx;
        in_data  = d;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Pulse sampled at edge t; spk_valid expected N+1 edges later.
    task automatic pulse_exp(input logic [N-1:0] e);
        @(negedge clk);
        pulse = 1'b1;
        @(posedge clk);
        #1;
        pulse = 1'b0;
        sb.push_back('{spk: e, cyc: cyc + N + 1});
        repeat (N + 2) @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset      = 1'b0;
        pulse      = 1'b0;
        in_valid   = 1'b0;
        in_idx     = '0;
        in_data    = '0;
        threshold  = 8'sd10;
        reset_mode = 1'b0;

        // Reset values
        repeat (2) @(negedge clk);
        chk("rst_spk_out", 32'(spk_out), 32'd0);
        chk("rst_spk_valid", 32'(spk_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);
        reset = 1'b1;
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        // Integrate and leak, reset-to-zero: V0 6 -> 9 -> 11 fires
        inject(3'd0, 8'sd6);  pulse_exp(4'b0000);
        inject(3'd0, 8'sd6);  pulse_exp(4'b0000);
        inject(3'd0, 8'sd6);  pulse_exp(4'b0001);

        // Refractory: two timesteps ignore input, third fires from V0=0
        inject(3'd0, 8'sd50); pulse_exp(4'b0000);
        inject(3'd0, 8'sd50); pulse_exp(4'b0000);
        inject(3'd0, 8'sd50); pulse_exp(4'b0001);
        pulse_exp(4'b0000);
        pulse_exp(4'b0000);

        // Saturation: I2 clamps to 127 and fires; I3 clamps to -128;
        // index 5 (would alias to n1) is ignored
        inject(3'd2, 8'sd100);
        inject(3'd2, 8'sd100);
        pulse_exp(4'b0100);
        inject(3'd3, -8'sd100);
        inject(3'd3, -8'sd100);
        inject(3'd5, 8'sd100);
        pulse_exp(4'b0000);

        // Pulse and input to n1 in the same idle cycle count together
        @(negedge clk);
        chk("in_ready_same_cycle", 32'(in_ready), 32'd1);
        pulse    = 1'b1;
        in_valid = 1'b1;
        in_idx   = 3'd1;
        in_data  = 8'sd12;
        @(posedge clk);
        #1;
        pulse    = 1'b0;
        in_valid = 1'b0;
        sb.push_back('{spk: 4'b0010, cyc: cyc + N + 1});
        repeat (N + 2) @(negedge clk);
        chk("spk_out_hold", 32'(spk_out), 32'b0010);

        // Reset mid-sweep: outputs cleared, no spk_valid for that sweep
        @(negedge clk);
        pulse = 1'b1;
        @(negedge clk);
        pulse = 1'b0;
        @(negedge clk);
        chk("busy_mid_sweep", 32'(busy), 32'd1);
        reset = 1'b0;
        #1;
        chk("midrst_spk_out", 32'(spk_out), 32'd0);
        chk("midrst_spk_valid", 32'(spk_valid), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_overrun", 32'(overrun), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (N + 2) @(negedge clk);
        pulse_exp(4'b0000);

        // Subtract mode: fires on pulse 3 leaving V0=1; after refractory,
        // 1 + 9 reaches threshold only if the residue was kept
        reset_mode = 1'b1;
        inject(3'd0, 8'sd6);  pulse_exp(4'b0000);
        inject(3'd0, 8'sd6);  pulse_exp(4'b0000);
        inject(3'd0, 8'sd6);  pulse_exp(4'b0001);
        pulse_exp(4'b0000);
        pulse_exp(4'b0000);
        inject(3'd0, 8'sd9);  pulse_exp(4'b0001);
        chk("spk_out_hold2", 32'(spk_out), 32'b0001);

        // Handshake and overrun
        chk("overrun_before", 32'(overrun), 32'd0);
        @(negedge clk);
        pulse = 1'b1;
        @(posedge clk);
        #1;
        pulse = 1'b0;
        sb.push_back('{spk: 4'b0000, cyc: cyc + N + 1});
        @(negedge clk);
        chk("busy_update", 32'(busy), 32'd1);
        chk("in_ready_update", 32'(in_ready), 32'd0);
        in_valid = 1'b1;
        in_idx   = 3'd1;
        in_data  = 8'sd12;
        @(negedge clk);
        pulse = 1'b1;
        @(posedge clk);
        #1;
        pulse = 1'b0;
        chk("overrun_set", 32'(overrun), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        // n1 must not have received the contribution offered during UPDATE
        pulse_exp(4'b0000);
        chk("overrun_sticky", 32'(overrun), 32'd1);

        for (int i = 0; i < 20; i++) begin
            if (sb.size() == 0) break;
            @(negedge clk);
        end
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
